// File: rtl/mem_fill_drain_ctrl.sv
// Fill/drain sequencer for a small scratch memory: writes a valid/ready word stream to
// consecutive addresses, then reads it back in order onto a valid/ready output stream.
// Optional frame checksum enabled by defining MEM_FILL_CHECKSUM_EN.
//
// Handshakes: a word moves on in_valid & in_ready (upstream) or on out_valid & out_ready
// (downstream) at the rising clock edge. in_ready is high for the whole of FILL and
// out_valid is high for the whole of DRAIN, independent of the partner's valid/ready.
module mem_fill_drain_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              done_q;

    // cnt is reset to 0 on every phase change, so it never leaves 0..DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        cnt_q   <= '0;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        if (cnt_q == LAST) begin
                            state_q <= S_DRAIN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (cnt_q == LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Memory read is combinational, so the drained word appears in the same cycle as its address.
    assign in_ready    = (state_q == S_FILL);
    assign out_valid   = (state_q == S_DRAIN);
    assign busy        = in_ready | out_valid;
    assign mem_wr      = in_ready & in_valid;
    assign mem_addr    = busy ? cnt_q : '0;
    assign mem_wdata   = in_ready ? in_data : '0;
    assign out_data    = out_valid ? mem_rdata : '0;
    assign done        = done_q;
    assign state_dbg_o = state_q;

`ifdef MEM_FILL_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q;
    logic [DATA_W-1:0] cks_d;

    always_comb begin
        cks_d = cks_q;
        if ((state_q == S_IDLE) && start) begin
            cks_d = '0;
        end else if (mem_wr) begin
            cks_d = cks_q + in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_fill_drain_ctrl.sv
// Directed, table-driven bench for mem_fill_drain_ctrl with a behavioural scratch memory.
module tb_mem_fill_drain_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
`ifdef MEM_FILL_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [1:0]    state_dbg;

  mem_fill_drain_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum), .state_dbg_o(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural scratch memory: synchronous write, combinational read
  logic [DW-1:0] mem_model [2**AW];
  always @(posedge clk) if (mem_wr) mem_model[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_model[mem_addr];

  // expected-output layout: {in_ready, mem_wr, mem_addr, mem_wdata, out_valid, out_data, busy, done}
  typedef struct packed {
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic [55:0]   exp;
  } vec_t;

  vec_t          tbl[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] cks_model = '0;

  logic [DW-1:0] w_basic [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic [DW-1:0] w_bub   [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
  logic [DW-1:0] w_bp    [4] = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
  logic [DW-1:0] w_cks   [4] = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0010};

  function automatic logic [39:0] e_idle(input logic d);
    return {1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, d};
  endfunction

  function automatic logic [39:0] e_fill(input int a, input logic [DW-1:0] wd, input logic wr);
    return {1'b1, wr, 3'(a), wd, 1'b0, 16'h0, 1'b1, 1'b0};
  endfunction

  function automatic logic [39:0] e_drain(input int a, input logic [DW-1:0] od);
    return {1'b0, 1'b0, 3'(a), 16'h0, 1'b1, od, 1'b1, 1'b0};
  endfunction

  function automatic logic [55:0] actual();
    return {in_ready, mem_wr, mem_addr, mem_wdata, out_valid, out_data, busy, done, checksum};
  endfunction

  task automatic check(input string name, input int idx, input logic [55:0] act, input logic [55:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic iv, input logic [DW-1:0] d, input logic ordy,
                     input logic [39:0] e, input logic [DW-1:0] c);
    vec_t v;
    v.start     = st;
    v.in_valid  = iv;
    v.in_data   = d;
    v.out_ready = ordy;
    v.exp       = {e, (CKS_EN ? c : 16'h0)};
    tbl.push_back(v);
  endtask

  // Builds one frame: start cycle, 4 fill words (optional bubble before word gap_at),
  // 4 drain words (optional stall at stall_addr), done cycle, two idle cycles.
  task automatic build_frame(input logic [DW-1:0] w [4], input int gap_at, input int gap_len,
                             input int stall_addr, input int stall_len, input bit extra_start);
    logic [DW-1:0] s;
    s = cks_model;
    add(1'b1, 1'b0, 16'h0, 1'b1, e_idle(1'b0), s);
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) add(1'b0, 1'b0, 16'h0, 1'b1, e_fill(i, 16'h0, 1'b0), s);
      add(extra_start && (i == 1), 1'b1, w[i], 1'b1, e_fill(i, w[i], 1'b1), s);
      s = s + w[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (i == stall_addr)
        for (int k = 0; k < stall_len; k++) add(1'b0, 1'b0, 16'h0, 1'b0, e_drain(i, w[i]), s);
      add(1'b0, 1'b0, 16'h0, 1'b1, e_drain(i, w[i]), s);
    end
    add(extra_start, 1'b0, 16'h0, 1'b1, e_idle(1'b1), s);
    add(1'b0, 1'b0, 16'h0, 1'b1, e_idle(1'b0), s);
    add(1'b0, 1'b0, 16'h0, 1'b1, e_idle(1'b0), s);
    cks_model = s;
  endtask

  // driver: apply each record just after a rising edge, compare mid-cycle
  task automatic run(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      start     = tbl[i].start;
      in_valid  = tbl[i].in_valid;
      in_data   = tbl[i].in_data;
      out_ready = tbl[i].out_ready;
      #2;
      check(name, i, actual(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("reset_outputs", 0, actual(), 56'h0);
    check("reset_state", 0, {54'h0, state_dbg}, 56'h0);
    @(negedge clk);
    rst_n = 1'b1;

    build_frame(w_basic, -1, 0, -1, 0, 1'b0);
    run("basic");

    build_frame(w_bub, 1, 2, -1, 0, 1'b0);
    run("bubbles");
    for (int i = 0; i < 4; i++) check("bubbles_mem", i, {40'h0, mem_model[i]}, {40'h0, w_bub[i]});

    build_frame(w_bp, -1, 0, 2, 3, 1'b0);
    run("backpressure");

    build_frame(w_basic, -1, 0, -1, 0, 1'b1);
    run("ignored_start");

    // reset while draining at cnt = 1
    build_frame(w_bp, -1, 0, -1, 0, 1'b0);
    while (tbl.size() > 7) void'(tbl.pop_back());
    run("pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_drain", 0, actual(), 56'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", 0, {actual(), state_dbg}, 58'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cks_model = '0;
    build_frame(w_basic, -1, 0, -1, 0, 1'b0);
    run("after_reset");

    build_frame(w_cks, -1, 0, -1, 0, 1'b0);
    run("cks_frame");
    check("cks_wrap", 0, {40'h0, checksum}, {40'h0, (CKS_EN ? 16'h0011 : 16'h0000)});

    build_frame(w_basic, -1, 0, -1, 0, 1'b0);
    run("cks_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fill_drain_ctrl.md
Name: mem_fill_drain_ctrl

Overview:
- Sequencer that sits directly upstream of the 4-word, 16-bit scratch Memory.
- Fill phase: accepts a valid/ready word stream (e.g. CNN partial results from the RISC CPU bus) and writes it to consecutive memory addresses.
- Drain phase: reads the words back in order and presents them on a valid/ready output stream to the downstream MAC stage.
- Owns the memory's addr/idata/wr pins exclusively.

Parameters:
- DATA_W, 16, word width; equals the Memory data width.
- ADDR_W, 3, width of the Memory address port.
- DEPTH, 4, words per frame; must satisfy 1 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  controller accepts a word this cycle.
- mem_addr  output  ADDR_W  to Memory addr.
- mem_wdata  output  DATA_W  to Memory idata.
- mem_wr  output  1  to Memory wr.
- mem_rdata  input  DATA_W  from Memory odata; combinational read of mem_addr.
- out_valid  output  1  downstream word valid.
- out_data  output  DATA_W  downstream word.
- out_ready  input  1  downstream accepts.
- busy  output  1  high in FILL or DRAIN.
- done  output  1  one-cycle pulse at end of frame.
- checksum  output  DATA_W  frame checksum (see Optional Feature).

Behaviour:
- Reset: clk and reset only as already decided — one clock; reset is asynchronous and active-low. rst_n low forces state = IDLE, cnt = 0, done = 0, checksum = 0 immediately. All combinational outputs then evaluate to 0: in_ready, mem_wr, out_valid, busy, mem_addr, mem_wdata.
- Reset asserted mid-frame abandons the frame. No done pulse; memory contents are left as they are.
- State register values: IDLE, FILL, DRAIN, DONE. Counter cnt is ADDR_W bits wide.
- IDLE:
  - start = 1 -> FILL, cnt = 0.
  - start in any other state is ignored.
- FILL:
  - in_ready = 1; mem_addr = cnt; mem_wdata = in_data; mem_wr = in_valid (combinational, same cycle).
  - On handshake (in_valid & in_ready): cnt increments.
  - On handshake with cnt == DEPTH-1: -> DRAIN, cnt = 0.
  - in_valid low: nothing written, cnt holds.
- DRAIN:
  - mem_wr = 0; mem_addr = cnt; out_valid = 1; out_data = mem_rdata (zero-latency combinational path through Memory).
  - On out_ready: cnt increments.
  - On out_ready with cnt == DEPTH-1: -> DONE.
  - While out_ready is low, out_data and mem_addr hold stable.
- DONE:
  - done = 1 for exactly one cycle, then -> IDLE with cnt = 0.
  - A start arriving during DONE is dropped; the requester must re-assert in IDLE.
- Outside FILL: in_ready = 0. Outside DRAIN: out_valid = 0.
- Timing:
  - Minimum frame is 1 (start) + DEPTH + DEPTH + 1 cycles.
  - DEPTH = 4 with no stalls: done rises 9 cycles after the start edge.
- cnt never exceeds DEPTH-1. For DEPTH = 2^ADDR_W it wraps to 0 naturally; no out-of-range address is ever driven.
- Words drain in the same order they were filled (address 0 first).

Optional Feature:
- Macro: MEM_FILL_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 on the start transition.
  - checksum adds in_data modulo 2^DATA_W on every FILL handshake.
  - The value holds through DRAIN, DONE and IDLE until the next start.
- Undefined: checksum is tied to 0 and no accumulator register exists.

Test Plan:
- Basic frame: reset, start, stream 0x0011, 0x0022, 0x0033, 0x0044 with in_valid constant and out_ready = 1.
  - -> mem_wr high on 4 consecutive cycles at addr 0..3.
  - -> out_data 0x0011, 0x0022, 0x0033, 0x0044 in order.
  - -> done pulses exactly once, 9 cycles after start.
- Input bubbles: in_valid low for 2 cycles between word 1 and word 2.
  - -> mem_wr low and mem_addr held at 1 during the gap.
  - -> memory ends with 4 correct words.
- Output backpressure: out_ready low for 3 cycles while addr = 2.
  - -> out_valid stays 1, out_data stays the word at addr 2, mem_addr stays 2.
  - -> order preserved, done delayed by 3 cycles.
- Ignored start: pulse start during FILL and during DONE.
  - -> no state change, no extra frame.
  - -> FSM returns to IDLE after one done pulse.
- Reset mid-DRAIN: drop rst_n at cnt = 1.
  - -> busy, out_valid and done go 0 immediately; no done pulse.
  - -> a new start runs a full correct frame.
- With MEM_FILL_CHECKSUM_EN: fill 0xFFFF, 0x0002, 0x0000, 0x0010.
  - -> checksum = 0x0011 (wraps modulo 2^16).
  - -> checksum clears to 0 on the next start.
  - -> without the macro, checksum reads 0 throughout.
